// File: rtl/lut_sweep_eval.sv
// Serially loaded N-input truth table with a registered point lookup and an
// exhaustive minterm sweep that reports every entry and counts the true ones.
module lut_sweep_eval #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_en,
  input  logic         load_bit,
  input  logic [N-1:0] in_vec,
  input  logic         start,
  output logic         f,
  output logic         sweep_valid,
  output logic [N-1:0] sweep_idx,
  output logic         sweep_f,
  output logic         busy,
  output logic         done,
  output logic [N:0]   ones_count
);

  localparam int DEPTH = 1 << N;
  localparam logic [N-1:0] LAST_IDX = N'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DEPTH-1:0] tt;
  logic [N-1:0]     idx_nxt;

  assign idx_nxt = sweep_idx + N'(1);

  // Status outputs are pure decodes of the registered state, so they also
  // clear the instant reset asserts.
  assign sweep_valid = (state == SWEEP);
  assign done        = (state == DONE);
  assign busy        = (state == SWEEP) || (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SWEEP;
      SWEEP:   if (sweep_idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the truth table is a flop vector, not a RAM, so it takes the async
  // reset like every other register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt         <= '0;
      f          <= 1'b0;
      sweep_idx  <= '0;
      sweep_f    <= 1'b0;
      ones_count <= '0;
    end else begin
      f <= tt[in_vec];
      case (state)
        IDLE: begin
          // start wins over load_en: the table is frozen from the sweep's first edge.
          if (start) begin
            sweep_idx  <= '0;
            sweep_f    <= tt[0];
            ones_count <= {N'(0), tt[0]};
          end else if (load_en) begin
            tt <= {tt[DEPTH-2:0], load_bit};
          end
        end
        SWEEP: begin
          if (sweep_idx != LAST_IDX) begin
            sweep_idx  <= idx_nxt;
            sweep_f    <= tt[idx_nxt];
            ones_count <= ones_count + {N'(0), tt[idx_nxt]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_sweep_eval.sv
// Directed bench for lut_sweep_eval: an N=3 instance checked every cycle
// against a behavioural model, plus an N=4 instance for the all-ones sweep.
module tb_lut_sweep_eval;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       load_en = 1'b0, load_bit = 1'b0, start = 1'b0;
  logic [2:0] in_vec = '0;
  logic       f, sweep_valid, sweep_f, busy, done;
  logic [2:0] sweep_idx;
  logic [3:0] ones_count;

  logic       load_en4 = 1'b0, load_bit4 = 1'b0, start4 = 1'b0;
  logic [3:0] in_vec4 = '0;
  logic       f4, sv4, sf4, busy4, done4;
  logic [3:0] idx4;
  logic [4:0] ones4;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  lut_sweep_eval #(.N(3)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_bit(load_bit),
    .in_vec(in_vec), .start(start), .f(f), .sweep_valid(sweep_valid),
    .sweep_idx(sweep_idx), .sweep_f(sweep_f), .busy(busy), .done(done),
    .ones_count(ones_count)
  );

  lut_sweep_eval #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load_en(load_en4), .load_bit(load_bit4),
    .in_vec(in_vec4), .start(start4), .f(f4), .sweep_valid(sv4),
    .sweep_idx(idx4), .sweep_f(sf4), .busy(busy4), .done(done4),
    .ones_count(ones4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model (N=3) ----------------
  // m_phase: -1 idle, 0..D-1 reporting that minterm, D = done cycle.
  logic [D-1:0] m_tt;
  int           m_phase;
  logic [2:0]   m_idx;
  logic         m_sf, m_f;
  logic [3:0]   m_ones;

  function automatic logic [3:0] ones_upto(input logic [D-1:0] t, input int k);
    int s = 0;
    for (int i = 0; i <= k; i++) s += int'(t[i]);
    return 4'(s);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tt <= '0; m_phase <= -1; m_idx <= '0; m_sf <= 1'b0; m_f <= 1'b0; m_ones <= '0;
    end else begin
      m_f <= m_tt[in_vec];
      if (m_phase < 0) begin
        if (start) begin
          m_phase <= 0; m_idx <= 3'd0; m_sf <= m_tt[0]; m_ones <= ones_upto(m_tt, 0);
        end else if (load_en) begin
          m_tt <= {m_tt[D-2:0], load_bit};
        end
      end else if (m_phase < D - 1) begin
        m_phase <= m_phase + 1;
        m_idx   <= 3'(m_phase + 1);
        m_sf    <= m_tt[m_phase + 1];
        m_ones  <= ones_upto(m_tt, m_phase + 1);
      end else if (m_phase == D - 1) begin
        m_phase <= D;
      end else begin
        m_phase <= -1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmp_f",     32'(f),           32'(m_f));
      check("cmp_valid", 32'(sweep_valid), 32'(m_phase >= 0 && m_phase < D));
      check("cmp_idx",   32'(sweep_idx),   32'(m_idx));
      check("cmp_sf",    32'(sweep_f),     32'(m_sf));
      check("cmp_busy",  32'(busy),        32'(m_phase >= 0));
      check("cmp_done",  32'(done),        32'(m_phase == D));
      check("cmp_ones",  32'(ones_count),  32'(m_ones));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [D-1:0] tt_vec = 8'b1011_1000;
  logic         exp_sf [D] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

  task automatic load_tt(input logic [D-1:0] bits);
    for (int i = D - 1; i >= 0; i--) begin
      @(negedge clk);
      load_en = 1'b1; load_bit = bits[i];
    end
    @(negedge clk);
    load_en = 1'b0; load_bit = 1'b0;
  endtask

  task automatic probe_f(input logic [2:0] v, input logic exp, input string name);
    in_vec = v;
    @(negedge clk);
    check(name, 32'(f), 32'(exp));
  endtask

  // mode 0: plain, 1: start/load_en pulsed mid-sweep, 2: start+load_en together
  task automatic sweep_check(input string tag, input int mode);
    @(negedge clk);
    start = 1'b1;
    if (mode == 2) begin load_en = 1'b1; load_bit = 1'b1; end
    @(negedge clk);
    start = 1'b0; load_en = 1'b0; load_bit = 1'b0;
    for (int k = 0; k < D; k++) begin
      if (k > 0) @(negedge clk);
      check({tag, "_idx"},   32'(sweep_idx),   32'(k));
      check({tag, "_sf"},    32'(sweep_f),     32'(exp_sf[k]));
      check({tag, "_valid"}, 32'(sweep_valid), 32'd1);
      if (mode == 1 && k == 2) begin start = 1'b1; load_en = 1'b1; load_bit = 1'b1; end
      if (mode == 1 && k == 4) begin start = 1'b0; load_en = 1'b0; load_bit = 1'b0; end
    end
    @(negedge clk);
    check({tag, "_done"},     32'(done),        32'd1);
    check({tag, "_done_vld"}, 32'(sweep_valid), 32'd0);
    check({tag, "_done_bsy"}, 32'(busy),        32'd1);
    check({tag, "_done_idx"}, 32'(sweep_idx),   32'd7);
    check({tag, "_ones"},     32'(ones_count),  32'd4);
    @(negedge clk);
    check({tag, "_idle_done"}, 32'(done),       32'd0);
    check({tag, "_idle_busy"}, 32'(busy),       32'd0);
    check({tag, "_idle_ones"}, 32'(ones_count), 32'd4);
  endtask

  initial begin
    int vcnt, dcnt;
    logic [4:0] ones_at_done;

    #1 rst_n = 1'b0;
    #3;
    check("rst_f",    32'(f),          32'd0);
    check("rst_busy", 32'(busy),       32'd0);
    check("rst_ones", 32'(ones_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Load and point lookups
    load_tt(tt_vec);
    check("model_tt", 32'(m_tt), 32'h0000_00b8);
    probe_f(3'b011, 1'b1, "f_011");
    probe_f(3'b110, 1'b0, "f_110");
    probe_f(3'b100, 1'b1, "f_100");

    // Clean sweep, then a sweep with ignored start/load_en pulses
    sweep_check("sweep1", 0);
    check("model_ones", 32'(m_ones), 32'd4);
    sweep_check("sweep2", 1);
    check("tt_kept", 32'(m_tt), 32'h0000_00b8);
    probe_f(3'b000, 1'b0, "f_000_after");
    probe_f(3'b111, 1'b1, "f_111_after");

    // Reset in the middle of a sweep
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_idx3", 32'(sweep_idx), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mr_f",     32'(f),           32'd0);
    check("mr_valid", 32'(sweep_valid), 32'd0);
    check("mr_idx",   32'(sweep_idx),   32'd0);
    check("mr_sf",    32'(sweep_f),     32'd0);
    check("mr_busy",  32'(busy),        32'd0);
    check("mr_done",  32'(done),        32'd0);
    check("mr_ones",  32'(ones_count),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mr_no_done", 32'(done), 32'd0);
    end
    for (int v = 0; v < D; v++) probe_f(3'(v), 1'b0, "mr_f_zero");

    // start and load_en in the same idle cycle
    load_tt(tt_vec);
    sweep_check("sweep3", 2);
    check("tt_kept2", 32'(m_tt), 32'h0000_00b8);

    // N=4: all-ones table
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      load_en4 = 1'b1; load_bit4 = 1'b1;
    end
    @(negedge clk);
    load_en4 = 1'b0; load_bit4 = 1'b0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    vcnt = 0; dcnt = 0; ones_at_done = '0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      if (sv4) vcnt++;
      if (done4) begin dcnt++; ones_at_done = ones4; end
    end
    check("n4_valid_cycles", 32'(vcnt),         32'd16);
    check("n4_done_pulses",  32'(dcnt),         32'd1);
    check("n4_ones_done",    32'(ones_at_done), 32'd16);
    check("n4_ones_hold",    32'(ones4),        32'd16);
    in_vec4 = 4'd9;
    @(negedge clk);
    check("n4_f", 32'(f4), 32'd1);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
